pe_requant_act: RTL and testbench
=================================

# pe_requant_act

Per-channel requantisation and activation stage that directly consumes the parallel output vector of the PE output buffer. It adds a signed bias, multiplies by an unsigned fixed-point scale, rounds, shifts, optionally applies ReLU, and saturates each channel to a narrow signed output. It is a fully pipelined 3-stage datapath with a serial coefficient-load port, and it feeds the next layer's input buffer.

## Interface
- DATA_WIDTH, 16: signed width of each input channel value.
- OUT_CHANNEL, 16: number of channels per vector.
- BIAS_WIDTH, 16: signed bias width. Must be ≤ DATA_WIDTH.
- SCALE_WIDTH, 16: unsigned scale width. Also the width of `i_cfg_data`.
- SHIFT, 15: right-shift applied after the multiply. Must be ≥ 1.
- OUT_WIDTH, 8: signed output width per channel.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  DATA_WIDTH*OUT_CHANNEL  input vector; channel k is in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- i_valid  in  1  `i_data` is valid this cycle. Single-cycle pulse or back-to-back.
- i_cfg_data  in  SCALE_WIDTH  coefficient word.
- i_cfg_valid  in  1  `i_cfg_data` is valid this cycle.
- o_data  out  OUT_WIDTH*OUT_CHANNEL  output vector; same channel packing as `i_data`.
- o_valid  out  1  `o_data` is valid.
- o_cfg_done  out  1  complete coefficient set loaded.

## Operation
- **Coefficient load**
  - 2*OUT_CHANNEL words per load, arriving on `i_cfg_valid` beats.
  - Words 0..OUT_CHANNEL-1 are the biases for ch0..chN-1. Only the low BIAS_WIDTH bits are used, taken as signed.
  - Words OUT_CHANNEL..2*OUT_CHANNEL-1 are the scales for ch0..chN-1, taken as unsigned.
  - `cfg_cnt` advances on each beat and wraps to 0 after word 2*OUT_CHANNEL-1.
  - Coefficient registers have no write-enable other than `i_cfg_valid`.
- **o_cfg_done**
  - Set on the clock edge that accepts the last word.
  - Cleared on the edge that accepts word 0 of a new load.
- **Per-channel datapath**
  - Stage 1: `s = i_data[k] + bias[k]`, kept at DATA_WIDTH+1 bits signed. No overflow.
  - Stage 2: `p = s * {1'b0, scale[k]}`, signed product of DATA_WIDTH+SCALE_WIDTH+2 bits.
  - Stage 3: `r = (p + 2^(SHIFT-1)) >>> SHIFT`. This is arithmetic shift with round-half-up (toward +inf on exact halves). One guard bit is added before the rounding addition.
  - Stage 3, then saturate `r` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The ReLU option is described under Configuration.
- The valid bit travels through a 3-deep shift register alongside the data. The pipeline has no stall; every `i_valid` produces exactly one `o_valid`.
- **Coefficient writes during traffic**
  - A coefficient write takes effect on the next edge.
  - An in-flight vector uses the bias value present when it passes stage 1 and the scale value present when it passes stage 2.
  - No error is flagged. Software must not mix loads with traffic.

## Timing
- Latency: `o_valid`/`o_data` are registered and appear exactly 3 cycles after the `i_valid` edge. Throughput is 1 vector per cycle.
- Reset values: `o_valid`=0, `o_data`=0, `o_cfg_done`=0, `cfg_cnt`=0, all bias=0, all scale=0, all pipeline registers=0.
  - With zero coefficients, any post-reset vector outputs 0.
- A reset mid-stream discards all in-flight vectors. No `o_valid` is produced for them.
- A reset mid-load restarts the load at word 0 and leaves `o_cfg_done`=0.
- `o_data` holds its last value while `o_valid`=0. Stage registers update only when their valid bit is 1.

## Configuration
- Macro: `PE_REQUANT_RELU_EN`.
- Defined: clamp range is [0, 2^(OUT_WIDTH-1)-1]; negative results become 0.
- Undefined: full signed saturation as described under Operation.

## Test plan
- **Unity scale.** Defaults. Load bias=10 and scale=32768 on all channels. Drive `i_data`=100 on ch0 → ch0=110, `o_valid` exactly 3 cycles later, `o_cfg_done`=1.
- **Positive saturation.** Same coefficients. Drive `i_data`=300 → 127. Drive -32768 → -128 without the macro, 0 with it.
- **Rounding.** Bias=0, scale=16384. Drive +3 → 2 and -3 → -1. Drive -50 with scale 32768 → -50 without the macro, 0 with it.
- **Back-to-back traffic.** 20 consecutive `i_valid` cycles with per-channel distinct coefficients → 20 consecutive `o_valid` cycles, with order and per-channel values matching a reference model.
- **Load wrap.** Issue 2*OUT_CHANNEL+1 cfg beats → `o_cfg_done` rises after beat 2N and falls on the extra beat, and ch0's bias is overwritten by that beat.
- **Reset mid-operation.**
  - Assert `rst_n`=0 with 2 vectors in flight → no `o_valid`, outputs 0.
  - After release, a vector with no reload → output 0 (scale=0).

Source files
------------

// File: rtl/pe_requant_act.sv
`timescale 1ns/1ps
// pe_requant_act: per-channel requantisation and activation.
// Three-stage pipeline per channel: add bias, multiply by unsigned scale,
// then round-half-up, arithmetic shift and saturate to OUT_WIDTH.
// Coefficients arrive serially: OUT_CHANNEL biases, then OUT_CHANNEL scales.
// Optional macro PE_REQUANT_RELU_EN: clamp the low end at 0 (ReLU) instead of
// full signed saturation.
module pe_requant_act #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_CHANNEL = 16,
  parameter int BIAS_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT       = 15,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*OUT_CHANNEL-1:0] i_data,
  input  logic                              i_valid,
  input  logic [SCALE_WIDTH-1:0]            i_cfg_data,
  input  logic                              i_cfg_valid,
  output logic [OUT_WIDTH*OUT_CHANNEL-1:0]  o_data,
  output logic                              o_valid,
  output logic                              o_cfg_done
);

  localparam int CW = (2 * OUT_CHANNEL > 1) ? $clog2(2 * OUT_CHANNEL) : 1;
  localparam int W1 = DATA_WIDTH + 1;
  localparam int W2 = DATA_WIDTH + SCALE_WIDTH + 2;
  // one guard bit so the rounding addition can never wrap
  localparam int W3 = W2 + 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(2 * OUT_CHANNEL - 1);

  localparam logic signed [W3-1:0] ROUND =
    {{(W3-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [W3-1:0] MAXV =
    {{(W3-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
`ifdef PE_REQUANT_RELU_EN
  localparam logic signed [W3-1:0] MINV = '0;
`else
  localparam logic signed [W3-1:0] MINV =
    {{(W3-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

  logic [CW-1:0] cfg_cnt;
  logic          v1_q;
  logic          v2_q;

  // Coefficient word counter and load-complete flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_cnt    <= '0;
      o_cfg_done <= 1'b0;
    end else if (i_cfg_valid) begin
      if (cfg_cnt == LAST_WORD) begin
        cfg_cnt    <= '0;
        o_cfg_done <= 1'b1;
      end else begin
        cfg_cnt <= cfg_cnt + 1'b1;
        if (cfg_cnt == '0) o_cfg_done <= 1'b0;
      end
    end
  end

  // Valid bit travels alongside the data; no stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      v1_q    <= i_valid;
      v2_q    <= v1_q;
      o_valid <= v2_q;
    end
  end

  for (genvar k = 0; k < OUT_CHANNEL; k++) begin : g_ch
    logic signed [BIAS_WIDTH-1:0]  bias_q;
    logic        [SCALE_WIDTH-1:0] scale_q;
    logic signed [W1-1:0]          s1_q;
    logic signed [W2-1:0]          p2_q;
    logic signed [OUT_WIDTH-1:0]   od_q;
    logic signed [DATA_WIDTH-1:0]  din;
    logic signed [W2-1:0]          a_ext;
    logic signed [W2-1:0]          b_ext;
    logic signed [W3-1:0]          rnd;
    logic signed [W3-1:0]          r;
    logic signed [OUT_WIDTH-1:0]   sat;

    assign din   = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign a_ext = {{(SCALE_WIDTH+1){s1_q[W1-1]}}, s1_q};
    assign b_ext = {{(DATA_WIDTH+2){1'b0}}, scale_q};
    assign rnd   = {p2_q[W2-1], p2_q} + ROUND;
    assign r     = rnd >>> SHIFT;

    // Coefficient capture for this channel's bias and scale slots
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bias_q  <= '0;
        scale_q <= '0;
      end else begin
        if (i_cfg_valid && cfg_cnt == CW'(k))
          bias_q <= i_cfg_data[BIAS_WIDTH-1:0];
        if (i_cfg_valid && cfg_cnt == CW'(k + OUT_CHANNEL))
          scale_q <= i_cfg_data;
      end
    end

    // Clamp the rounded result into the output range
    always_comb begin
      sat = r[OUT_WIDTH-1:0];
      if (r > MAXV)
        sat = MAXV[OUT_WIDTH-1:0];
      else if (r < MINV)
        sat = MINV[OUT_WIDTH-1:0];
    end

    // Datapath stages; each holds unless its valid bit is set
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= '0;
        p2_q <= '0;
        od_q <= '0;
      end else begin
        if (i_valid)
          s1_q <= {din[DATA_WIDTH-1], din} +
                  {{(W1-BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
        if (v1_q)
          p2_q <= a_ext * b_ext;
        if (v2_q)
          od_q <= sat;
      end
    end

    assign o_data[k*OUT_WIDTH +: OUT_WIDTH] = od_q;
  end

endmodule

// File: tb/tb_pe_requant_act.sv
`timescale 1ns/1ps
// Self-checking bench for pe_requant_act with a behavioural reference model.
module tb_pe_requant_act;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int SH = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW*N-1:0]   i_data;
  logic              i_valid;
  logic [15:0]       i_cfg_data;
  logic              i_cfg_valid;
  logic [OW*N-1:0]   o_data;
  logic              o_valid;
  logic              o_cfg_done;

  int checks = 0;
  int errors = 0;

  int     m_bias [N];
  longint m_scale[N];
  int     m_cnt;

  always #5 clk = ~clk;

  pe_requant_act dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_cfg_data(i_cfg_data), .i_cfg_valid(i_cfg_valid),
    .o_data(o_data), .o_valid(o_valid), .o_cfg_done(o_cfg_done)
  );

  function automatic int model_ch(int d, int b, longint sc);
    longint p, num, q, den;
    den = 64'd1 << SH;
    p   = longint'(d + b) * sc;
    num = p + den / 2;
    q   = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    if (q > 127) q = 127;
`ifdef PE_REQUANT_RELU_EN
    if (q < 0) q = 0;
`else
    if (q < -128) q = -128;
`endif
    return int'(q);
  endfunction

  function automatic logic [OW*N-1:0] model_vec(logic [DW*N-1:0] v);
    logic [OW*N-1:0] e;
    int d, r;
    for (int k = 0; k < N; k++) begin
      d = int'($signed(v[k*DW +: DW]));
      r = model_ch(d, m_bias[k], m_scale[k]);
      e[k*OW +: OW] = r[7:0];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_bias[k]  = 0;
      m_scale[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic cfg_beat(input logic [15:0] w);
    @(negedge clk);
    i_cfg_valid = 1'b1;
    i_cfg_data  = w;
    @(posedge clk);
    #1;
    i_cfg_valid = 1'b0;
    if (m_cnt < N) m_bias[m_cnt] = int'($signed(w));
    else           m_scale[m_cnt-N] = longint'(w);
    m_cnt = (m_cnt == 2*N-1) ? 0 : m_cnt + 1;
  endtask

  task automatic load_uniform(input int b, input int s);
    logic [31:0] bb, ss;
    bb = b;
    ss = s;
    for (int i = 0; i < N; i++) cfg_beat(bb[15:0]);
    for (int i = 0; i < N; i++) cfg_beat(ss[15:0]);
  endtask

  task automatic rand_vec(input int lo, input int hi, output logic [DW*N-1:0] v);
    int d;
    for (int k = 0; k < N; k++) begin
      d = int'($urandom_range(hi - lo)) + lo;
      v[k*DW +: DW] = d[15:0];
    end
  endtask

  task automatic fill_vec(input int val, output logic [DW*N-1:0] v);
    int d;
    d = val;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = d[15:0];
  endtask

  // drives one vector and waits (bounded) for its output; lat=-1 on timeout
  task automatic run_vector(input logic [DW*N-1:0] v, output logic [OW*N-1:0] out,
                            output int lat);
    lat = -1;
    out = '0;
    @(negedge clk);
    i_data  = v;
    i_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) i_valid = 1'b0;
      if (o_valid && lat < 0) begin
        lat = n;
        out = o_data;
      end
    end
  endtask

  task automatic test_reset();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out;
    int lat;
    rst_n = 1'b0; i_valid = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = '0; i_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h done=%b, want 0/0/0", o_valid, o_data, o_cfg_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rand_vec(-32768, 32767, v);
    run_vector(v, out, lat);
    checks++;
    if (lat !== 3 || out !== '0) begin
      errors++;
      $display("FAIL reset_zero_coeff: got lat=%0d data=%h, want lat=3 data=0", lat, out);
    end
  endtask

  task automatic test_unity();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out, e;
    int lat;
    load_uniform(10, 32768);
    checks++;
    if (o_cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL unity_cfg_done: got %b want 1", o_cfg_done);
    end
    rand_vec(-100, 100, v);
    v[15:0] = 16'd100;
    e = model_vec(v);
    run_vector(v, out, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL unity_latency: got %0d want 3", lat);
    end
    checks++;
    if (out[7:0] !== 8'd110) begin
      errors++;
      $display("FAIL unity_ch0: got %0d want 110", $signed(out[7:0]));
    end
    checks++;
    if (out !== e) begin
      errors++;
      $display("FAIL unity_vec: got %h want %h", out, e);
    end
  endtask

  task automatic test_saturation();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out, e;
    int lat;
    fill_vec(300, v);
    run_vector(v, out, lat);
    e = {N{8'h7F}};
    checks++;
    if (lat !== 3 || out !== e) begin
      errors++;
      $display("FAIL sat_pos: got lat=%0d data=%h want lat=3 data=%h", lat, out, e);
    end
    fill_vec(-32768, v);
    run_vector(v, out, lat);
`ifdef PE_REQUANT_RELU_EN
    e = '0;
`else
    e = {N{8'h80}};
`endif
    checks++;
    if (lat !== 3 || out !== e) begin
      errors++;
      $display("FAIL sat_neg: got lat=%0d data=%h want lat=3 data=%h", lat, out, e);
    end
  endtask

  task automatic test_rounding();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out, e;
    int lat, d;
    load_uniform(0, 16384);
    for (int k = 0; k < N; k++) begin
      d = (k % 2 == 0) ? 3 : -3;
      v[k*DW +: DW] = d[15:0];
    end
    run_vector(v, out, lat);
    checks++;
    if (out[7:0] !== 8'd2 || out[15:8] !== 8'hFF) begin
      errors++;
      $display("FAIL round_half: got ch0=%0d ch1=%0d want 2 -1", $signed(out[7:0]), $signed(out[15:8]));
    end
    e = model_vec(v);
    checks++;
    if (lat !== 3 || out !== e) begin
      errors++;
      $display("FAIL round_vec: got lat=%0d data=%h want lat=3 data=%h", lat, out, e);
    end
    load_uniform(0, 32768);
    fill_vec(-50, v);
    run_vector(v, out, lat);
`ifdef PE_REQUANT_RELU_EN
    e = '0;
`else
    e = {N{8'hCE}};
`endif
    checks++;
    if (lat !== 3 || out !== e) begin
      errors++;
      $display("FAIL round_neg50: got lat=%0d data=%h want lat=3 data=%h", lat, out, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW*N-1:0] vecs[20];
    logic [OW*N-1:0] exps[20];
    int got, first, last, bad;
    for (int k = 0; k < N; k++) cfg_beat(16'($urandom_range(400)) - 16'd200);
    for (int k = 0; k < N; k++) cfg_beat(16'($urandom_range(65535)));
    for (int i = 0; i < 20; i++) begin
      rand_vec(-32768, 32767, vecs[i]);
      if (i < 10) rand_vec(-300, 300, vecs[i]);
      exps[i] = model_vec(vecs[i]);
    end
    got = 0; first = -1; last = -1; bad = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          i_data  = vecs[i];
          i_valid = 1'b1;
        end
        @(negedge clk);
        i_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 30; c++) begin
          @(posedge clk);
          #1;
          if (o_valid) begin
            if (first < 0) first = c;
            last = c;
            if (got < 20 && o_data !== exps[got]) begin
              bad++;
              $display("FAIL b2b_data[%0d]: got %h want %h", got, o_data, exps[got]);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (got != 20 || first != 3 || last != 22) begin
      errors++;
      $display("FAIL b2b_timing: got count=%0d first=%0d last=%0d want 20/3/22", got, first, last);
    end
  endtask

  task automatic test_load_wrap();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out, e;
    logic [15:0] w;
    int lat, b0;
    b0 = int'($urandom_range(100)) - 50;
    for (int i = 0; i < 2*N; i++) begin
      if (i == 0) w = b0[15:0];
      else if (i < N) w = 16'($urandom_range(100)) - 16'd50;
      else w = 16'd32768;
      cfg_beat(w);
      if (i == 0) begin
        checks++;
        if (o_cfg_done !== 1'b0) begin
          errors++;
          $display("FAIL wrap_done_word0: got %b want 0", o_cfg_done);
        end
      end else if (i == 2*N-2) begin
        checks++;
        if (o_cfg_done !== 1'b0) begin
          errors++;
          $display("FAIL wrap_done_early: got %b want 0", o_cfg_done);
        end
      end else if (i == 2*N-1) begin
        checks++;
        if (o_cfg_done !== 1'b1) begin
          errors++;
          $display("FAIL wrap_done_last: got %b want 1", o_cfg_done);
        end
      end
    end
    b0 = b0 + 20;
    cfg_beat(b0[15:0]);
    checks++;
    if (o_cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done_extra: got %b want 0", o_cfg_done);
    end
    rand_vec(-50, 50, v);
    e = model_vec(v);
    run_vector(v, out, lat);
    checks++;
    if (lat !== 3 || out !== e) begin
      errors++;
      $display("FAIL wrap_bias_overwrite: got lat=%0d data=%h want lat=3 data=%h", lat, out, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW*N-1:0] v;
    logic [OW*N-1:0] out;
    int lat, seen;
    load_uniform(10, 32768);
    rand_vec(-100, 100, v);
    @(negedge clk);
    i_data = v; i_valid = 1'b1;
    @(negedge clk);
    rand_vec(-100, 100, v);
    i_data = v;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got valid=%b data=%h done=%b want 0/0/0", o_valid, o_data, o_cfg_done);
    end
    model_reset();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 4) rst_n = 1'b1;
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0 || o_data !== '0) begin
      errors++;
      $display("FAIL midrst_flush: got valid_count=%0d data=%h want 0/0", seen, o_data);
    end
    rand_vec(-32768, 32767, v);
    run_vector(v, out, lat);
    checks++;
    if (lat !== 3 || out !== model_vec(v)) begin
      errors++;
      $display("FAIL midrst_no_reload: got lat=%0d data=%h want lat=3 data=0", lat, out);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_load_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
